// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_framer
//  Purpose  : UART transmitter with an input FIFO and configurable data width,
//             parity and stop bits. All outputs registered.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_data_valid,
    output logic                          o_fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_dataline,
    output logic                          o_busy,
    output logic                          o_send_complete
);

    localparam int                   c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                   c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_PTR_W:0]     c_FULL      = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_BAUD_W-1:0]  c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT-1);
    localparam logic [3:0]           c_LAST_DATA = 4'(DATA_BITS-1);
    localparam logic [3:0]           c_LAST_STOP = 4'(STOP_BITS-1);
    localparam logic                 c_HAS_PAR   = (PARITY != 0);
    localparam logic                 c_ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]     r_count, w_count_nxt;
    logic                 r_fifo_full, r_overflow;

    state_t               r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_dataline, r_busy, r_send_complete;

    logic                 w_push, w_pop, w_bit_end, w_last_stop, w_frame_end, w_line;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // Full comes from the registered count, so a same-cycle pop never frees a slot.
    assign w_push      = i_data_valid & ~r_fifo_full;
    assign w_bit_end   = (r_baud == c_BAUD_LAST);
    assign w_last_stop = (r_bit_idx == c_LAST_STOP);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && w_last_stop;
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_par  = (^w_head) ^ c_ODD_PAR;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_parity;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_fifo_full <= (w_count_nxt == c_FULL);
            r_overflow  <= i_data_valid & r_fifo_full;
        end
    end

    // Line, busy and completion are registered from the current state, so the
    // line trails the state by one cycle and all three stay mutually aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_baud          <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            r_dataline      <= 1'b1;
            r_busy          <= 1'b0;
            r_send_complete <= 1'b0;
        end else begin
            r_dataline      <= w_line;
            r_busy          <= (r_state != S_IDLE);
            r_send_complete <= w_frame_end;

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_parity  <= w_head_par;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= c_HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (!w_last_stop) begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end else if (w_pop) begin
                            r_shift   <= w_head;
                            r_parity  <= w_head_par;
                            r_bit_idx <= '0;
                            r_state   <= S_START;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_full     = r_fifo_full;
    assign o_fifo_count    = r_count;
    assign o_overflow      = r_overflow;
    assign o_dataline      = r_dataline;
    assign o_busy          = r_busy;
    assign o_send_complete = r_send_complete;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_framer
//  Purpose  : Five configurations driven by one stimulus stream and compared
//             every cycle against a frame-level model; 8N1 line decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int N = 5;

    logic              clk;
    logic              rst_n;
    logic [8:0]        data;
    logic              valid;
    logic [N-1:0]      line, busy, sc, ovf, full;
    logic [N-1:0][3:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int cfg_c(int g); return (g == 4) ? 2 : 10; endfunction
    function automatic int cfg_d(int g); return (g == 3) ? 7 : (g == 4) ? 9 : 8; endfunction
    function automatic int cfg_p(int g); return (g == 1) ? 1 : (g == 2 || g == 4) ? 2 : 0; endfunction
    function automatic int cfg_s(int g); return (g == 3) ? 2 : 1; endfunction
    function automatic int cfg_f(int g); return (g == 4) ? 2 : 4; endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int C = cfg_c(g);
        localparam int D = cfg_d(g);
        localparam int P = cfg_p(g);
        localparam int S = cfg_s(g);
        localparam int F = cfg_f(g);
        logic [$clog2(F):0] w_cnt;
        assign cnt[g] = 4'(w_cnt);
        uart_tx_framer #(
            .CLKS_PER_BIT(C), .DATA_BITS(D), .PARITY(P), .STOP_BITS(S), .FIFO_DEPTH(F)
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_data(data[D-1:0]), .i_data_valid(valid),
            .o_fifo_full(full[g]), .o_fifo_count(w_cnt), .o_overflow(ovf[g]),
            .o_dataline(line[g]), .o_busy(busy[g]), .o_send_complete(sc[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: queue of words, and for the frame on the wire a
    // bit array plus the cycle position within it.
    int  m_mem  [N][16];
    int  m_head [N], m_size [N], m_pos [N], m_len [N];
    bit  m_act  [N];
    bit  m_fr   [N][16];
    bit  e_line [N], e_busy [N], e_sc [N], e_ovf [N], e_full [N];
    int  e_cnt  [N];
    int  tx_log [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_head[i] = 0; m_size[i] = 0; m_pos[i] = 0; m_act[i] = 0; m_len[i] = 0;
            e_line[i] = 1; e_busy[i] = 0; e_sc[i] = 0; e_ovf[i] = 0; e_full[i] = 0; e_cnt[i] = 0;
        end
    endfunction

    function automatic void load_frame(int i, int w);
        int k = 1;
        bit par = (cfg_p(i) == 2);
        m_fr[i][0] = 1'b0;
        for (int b = 0; b < cfg_d(i); b++) begin
            m_fr[i][k] = w[b];
            par ^= w[b];
            k++;
        end
        if (cfg_p(i) != 0) begin
            m_fr[i][k] = par;
            k++;
        end
        for (int s = 0; s < cfg_s(i); s++) begin
            m_fr[i][k] = 1'b1;
            k++;
        end
        m_len[i] = k;
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < N; i++) begin
            int c = cfg_c(i);
            int f = cfg_f(i);
            bit pre_full = (m_size[i] == f);
            bit last = m_act[i] && (m_pos[i] == m_len[i] * c - 1);
            bit pop = (m_size[i] > 0) && (!m_act[i] || last);
            e_line[i] = m_act[i] ? m_fr[i][m_pos[i] / c] : 1'b1;
            e_busy[i] = m_act[i];
            e_sc[i]   = last;
            if (m_act[i] && !last) begin
                m_pos[i]++;
            end else if (pop) begin
                int w = m_mem[i][m_head[i]];
                m_head[i] = (m_head[i] + 1) % f;
                m_size[i]--;
                load_frame(i, w);
                m_act[i] = 1;
                m_pos[i] = 0;
                if (i == 0) tx_log.push_back(w);
            end else begin
                m_act[i] = 0;
            end
            if (valid && !pre_full) begin
                m_mem[i][(m_head[i] + m_size[i]) % f] = int'(data) & ((1 << cfg_d(i)) - 1);
                m_size[i]++;
            end
            e_ovf[i]  = valid && pre_full;
            e_cnt[i]  = m_size[i];
            e_full[i] = (m_size[i] == f);
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d_line", i), 32'(line[i]), 32'(e_line[i]));
            check($sformatf("u%0d_busy", i), 32'(busy[i]), 32'(e_busy[i]));
            check($sformatf("u%0d_done", i), 32'(sc[i]),   32'(e_sc[i]));
            check($sformatf("u%0d_ovf", i),  32'(ovf[i]),  32'(e_ovf[i]));
            check($sformatf("u%0d_full", i), 32'(full[i]), 32'(e_full[i]));
            check($sformatf("u%0d_cnt", i),  32'(cnt[i]),  32'(e_cnt[i]));
        end
    endtask

    task automatic cycle(input bit v, input logic [8:0] d);
        valid = v;
        data  = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 9'h000);
    endtask

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    // 8N1 decoder on instance 0, sampling each bit at its centre.
    initial begin
        bit         rx_on = 0;
        int         rx_t  = 0;
        logic [7:0] rx_sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_on = 0;
            end else if (!rx_on) begin
                if (line[0] == 1'b0) begin
                    rx_on = 1;
                    rx_t  = 0;
                end
            end else begin
                rx_t++;
                if (rx_t == 5) check("rx_start", 32'(line[0]), 32'd0);
                if (rx_t >= 15 && rx_t < 95 && (rx_t % 10) == 5) rx_sh[(rx_t - 15) / 10] = line[0];
                if (rx_t == 95) begin
                    check("rx_stop", 32'(line[0]), 32'd1);
                    check("rx_pending", 32'(tx_log.size() > 0), 32'd1);
                    if (tx_log.size() > 0) check("rx_word", 32'(rx_sh), 32'(tx_log.pop_front()));
                    rx_on = 0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        model_reset();
        hold_reset(3);
        rst_n = 1'b1;

        // single word, then full-FIFO burst with dropped writes
        cycle(1'b1, 9'h055);
        idle(120);
        cycle(1'b1, 9'h001); cycle(1'b1, 9'h002); cycle(1'b1, 9'h003);
        cycle(1'b1, 9'h004); cycle(1'b1, 9'h0FF); cycle(1'b1, 9'h010);
        cycle(1'b1, 9'h011);
        idle(560);

        // parity corner words and a 7-bit pattern
        cycle(1'b1, 9'h007); idle(130);
        cycle(1'b1, 9'h000); idle(130);
        cycle(1'b1, 9'h041); idle(130);
        cycle(1'b1, 9'h1FF); idle(130);

        // asynchronous reset in the middle of a data bit with words queued
        cycle(1'b1, 9'h012); cycle(1'b1, 9'h034); cycle(1'b1, 9'h056);
        idle(30);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_u%0d_line", i), 32'(line[i]), 32'd1);
            check($sformatf("rst_u%0d_busy", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_u%0d_cnt", i),  32'(cnt[i]),  32'd0);
            check($sformatf("rst_u%0d_full", i), 32'(full[i]), 32'd0);
        end
        model_reset();
        tx_log.delete();
        hold_reset(2);
        rst_n = 1'b1;
        cycle(1'b1, 9'h0A3);
        idle(130);

        // random bursts and gaps
        for (int b = 0; b < 60; b++) begin
            int len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) cycle(1'b1, 9'($urandom_range(0, 511)));
            idle($urandom_range(0, 150));
        end
        idle(600);
        check("rx_drain", 32'(tx_log.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
